// File: rtl/seq_mult_param.sv
// seq_mult_param: shift-add multiplier, signed/unsigned, early exit once multiplier bits run out
module seq_mult_param #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           signed_mode,
  input  logic [W-1:0]   in1,
  input  logic [W-1:0]   in2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   m_q, m_d;
  logic [2*W-1:0] s_q, s_d, acc_q, acc_d, out_q, out_d;
  logic           neg_q, neg_d;
  logic [W-1:0]   mag1, mag2;
  // -2^(W-1) negates to 2^(W-1), which still fits as an unsigned W-bit magnitude
  assign mag1 = (signed_mode && in1[W-1]) ? -in1 : in1;
  assign mag2 = (signed_mode && in2[W-1]) ? -in2 : in2;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q == RUN || state_q == DONE;
  assign out       = out_q;
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (in_valid) begin
        m_d     = mag1;
        s_d     = {{W{1'b0}}, mag2};
        neg_d   = signed_mode && (in1[W-1] ^ in2[W-1]);
        acc_d   = '0;
        state_d = RUN;
      end
      RUN: if (m_q != '0) begin
        acc_d = m_q[0] ? acc_q + s_q : acc_q;
        m_d   = m_q >> 1;
        s_d   = s_q << 1;
      end else begin
        out_d   = neg_q ? -acc_q : acc_q;
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      s_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      out_q   <= out_d;
    end
  end
endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed checks of latency, products, DONE hold and async reset
module tb_seq_mult_param;
  localparam int W = 8;
  logic           clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, signed_mode = 1'b0, out_ready = 1'b0;
  logic [W-1:0]   in1 = '0, in2 = '0;
  logic           in_ready, out_valid, busy;
  logic [2*W-1:0] out;
  int total = 0, bad = 0;

  seq_mult_param #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .in1(in1), .in2(in2), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", {31'd0, in_ready}, 32'd1);
    signed_mode = m;
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in1 = W'($urandom);
    in2 = W'($urandom);
    signed_mode = 1'($urandom);
  endtask

  task automatic wait_result(input string tag, input int lat, input logic [2*W-1:0] exp);
    repeat (lat - 1) @(posedge clk);
    #1;
    chk({tag, "_valid_early"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_out"}, {16'd0, out}, {16'd0, exp});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #3;
    chk("rst_out", {16'd0, out}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    start(1'b0, 8'd255, 8'd255);
    wait_result("u255x255", 9, 16'hFE01);
    release_out();
    start(1'b0, 8'd0, 8'hAB);
    wait_result("u0xAB", 1, 16'h0000);
    release_out();
    start(1'b0, 8'd3, 8'd5);
    wait_result("u3x5", 3, 16'h000F);
    repeat (5) begin
      in_valid = ~in_valid;
      in1 = W'($urandom);
      in2 = W'($urandom);
      @(posedge clk);
      #1;
      chk("hold_out", {16'd0, out}, 32'h000F);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_out();
    start(1'b1, 8'h80, 8'h80);
    wait_result("s_m128xm128", 9, 16'h4000);
    release_out();
    start(1'b1, 8'hFF, 8'h01);
    wait_result("s_m1x1", 2, 16'hFFFF);
    release_out();
    chk("idle_retains_out", {16'd0, out}, 32'h0000FFFF);
    start(1'b0, 8'd200, 8'd7);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_rst_out", {16'd0, out}, 32'd0);
    chk("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_busy", {31'd0, busy}, 32'd0);
    start(1'b0, 8'd2, 8'd2);
    wait_result("u2x2", 3, 16'h0004);
    release_out();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_mult_param.md
SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width in bits (W >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair and mode are offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-007 The block SHALL have port in1, input, W bits: multiplier.
REQ-008 The block SHALL have port in2, input, W bits: multiplicand.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result on out is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port out, output, 2W bits: the product, registered.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 An accept SHALL be in_valid && in_ready at a rising edge; on accept the block SHALL latch signed_mode, |in1| into the multiplier register M, |in2| zero-extended to 2W bits into the shifted register S, and the result sign into neg = signed_mode && (in1[W-1] ^ in2[W-1]), clear the accumulator, and enter RUN.
REQ-015 Magnitudes SHALL be taken only when signed_mode = 1 and the operand MSB = 1; the magnitude of -2^(W-1) SHALL be 2^(W-1), representable in W unsigned bits.
REQ-016 In each RUN cycle with M != 0: the accumulator SHALL add S when M[0] = 1, M SHALL shift right by 1, and S SHALL shift left by 1 (2W bits, no overflow possible).
REQ-017 In a RUN cycle with M == 0, the block SHALL load out with the accumulator, or with its 2W-bit two's-complement negation when neg = 1, and enter DONE (early termination).
REQ-018 Latency SHALL be: for an accept at edge k, out_valid rises after edge k+N+1, where N is the bit-length of |in1| (N = 0 for zero, maximum W); no other cycle count is permitted.
REQ-019 In DONE, out and out_valid SHALL hold stable until out_ready = 1; at the edge with out_ready = 1 the block SHALL return to IDLE.
REQ-020 in_valid SHALL be ignored outside IDLE; operands changing during RUN or DONE SHALL not affect the result.
REQ-021 out SHALL retain the last result in IDLE and RUN, and SHALL change only on entry to DONE.
REQ-022 For unsigned operation, out SHALL always be <= (2^W-1)^2 (0xFE01 for W = 8); for signed operation, out SHALL equal the exact signed product in 2W bits (no overflow case exists).
REQ-023 When in RUN, the block SHALL be in RUN for at most W+1 consecutive cycles.
REQ-024 The FSM SHALL never enter an unencoded state; any illegal encoding SHALL return to IDLE at the next edge.

Reset
REQ-025 While rst_n = 0, the block SHALL immediately force state IDLE, out = 0, out_valid = 0, busy = 0, and the accumulator, M, S and neg = 0, independent of clk.
REQ-026 When reset asserts mid-RUN or mid-DONE, the block SHALL discard the operation without producing a result.
REQ-027 After rst_n deasserts, in_ready SHALL be 1 from the first edge.

Verification (W = 8)
REQ-028 The bench SHALL drive unsigned 255 x 255 and check out = 0xFE01, with out_valid 9 edges after the accept.
REQ-029 The bench SHALL drive unsigned in1 = 0, in2 = 0xAB and check out = 0x0000, with out_valid 1 edge after the accept.
REQ-030 The bench SHALL drive unsigned 3 x 5 and check out = 0x000F, with out_valid 3 edges after the accept.
REQ-031 The bench SHALL drive signed -128 x -128 and check out = 0x4000 after 9 edges, and signed -1 x 1 and check out = 0xFFFF after 2 edges.
REQ-032 The bench SHALL hold out_ready = 0 for 5 cycles in DONE while toggling in_valid and operands, and check that out, out_valid = 1 and in_ready = 0 stay stable, then return to IDLE one edge after out_ready = 1.
REQ-033 The bench SHALL pulse rst_n low 3 cycles after an accept of 200 x 7, and check out = 0, out_valid = 0 and busy = 0 immediately, in_ready = 1 after release, and a fresh 2 x 2 giving 0x0004.
